// File: rtl/cam_bus_emulator.sv
// Transmit side of an OV7670-style parallel camera bus.
// Generates pclk/vsync/href/data from an internal RGB565 test-pattern source.
// All bus updates are registered at the last clk_in of each pclk period, so
// they appear while pclk is low and are stable across the following high phase.
//
// Handshake: there is no valid/ready pair. en_in is a level request that is
// only looked at on frame boundaries (leaving IDLE, and at the end of VFP).
// frame_done_out is a single clk_in strobe at the end of each frame.
module cam_bus_emulator #(
   parameter int WIDTH       = 320,
   parameter int HEIGHT      = 240,
   parameter int PCLK_DIV    = 4,
   parameter int HBLANK      = 144,
   parameter int VSYNC_LINES = 3,
   parameter int VBP_LINES   = 17,
   parameter int VFP_LINES   = 10
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        en_in,
   input  logic [1:0]  pattern_in,
   input  logic [15:0] solid_in,
   output logic        pclk_out,
   output logic        vsync_out,
   output logic        href_out,
   output logic [7:0]  data_out,
   output logic        frame_done_out,
   output logic        busy_out,
   output logic [2:0]  dbg_state_out
);

   localparam int LINE_LEN = 2 * WIDTH + HBLANK;
   localparam int DW       = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;
   localparam int BAR_W    = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

   localparam logic [DW-1:0] D_LAST   = DW'(PCLK_DIV - 1);
   localparam logic [DW-1:0] D_HALF   = DW'(PCLK_DIV / 2);
   localparam logic [15:0]   P_LAST   = 16'(LINE_LEN - 1);
   localparam logic [15:0]   HREF_END = 16'(2 * WIDTH);
   localparam logic [15:0]   BAR_W16  = 16'(BAR_W);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBP    = 3'd2,
      ACTIVE = 3'd3,
      VFP    = 3'd4
   } state_t;

   state_t         state, nxt_state;
   logic [DW-1:0]  div_cnt;
   logic [15:0]    p, nxt_p;
   logic [15:0]    line, nxt_line;
   logic [1:0]     pat, nxt_pat;
   logic [15:0]    solid, nxt_solid;
   logic           boundary;
   logic           frame_end;
   logic [15:0]    last_line;

   logic [15:0]    pix_x, pix_y, bar, pix;
   logic [2:0]     bar_sel;
   logic           href_nxt;
   logic [7:0]     byte_nxt;

   assign boundary      = (div_cnt == D_LAST);
   assign pclk_out      = (div_cnt >= D_HALF);
   assign busy_out      = (state != IDLE);
   assign dbg_state_out = state;

   // Index of the final line of the current state.
   always_comb begin
      last_line = 16'd0;
      case (state)
         VSYNC:   last_line = 16'(VSYNC_LINES - 1);
         VBP:     last_line = 16'(VBP_LINES - 1);
         ACTIVE:  last_line = 16'(HEIGHT - 1);
         VFP:     last_line = 16'(VFP_LINES - 1);
         default: last_line = 16'd0;
      endcase
   end

   // Next state and counters; nothing moves except on a pclk period boundary.
   always_comb begin
      nxt_state = state;
      nxt_p     = p;
      nxt_line  = line;
      nxt_pat   = pat;
      nxt_solid = solid;
      frame_end = 1'b0;
      if (boundary) begin
         if (state == IDLE) begin
            if (en_in) begin
               nxt_state = VSYNC;
               nxt_pat   = pattern_in;
               nxt_solid = solid_in;
               nxt_p     = 16'd0;
               nxt_line  = 16'd0;
            end
         end else if (p != P_LAST) begin
            nxt_p = p + 16'd1;
         end else begin
            nxt_p = 16'd0;
            if (line != last_line) begin
               nxt_line = line + 16'd1;
            end else begin
               nxt_line = 16'd0;
               case (state)
                  VSYNC:  nxt_state = VBP;
                  VBP:    nxt_state = ACTIVE;
                  ACTIVE: nxt_state = VFP;
                  default: begin
                     // End of VFP: chain straight into the next frame if still enabled.
                     frame_end = 1'b1;
                     if (en_in) begin
                        nxt_state = VSYNC;
                        nxt_pat   = pattern_in;
                        nxt_solid = solid_in;
                     end else begin
                        nxt_state = IDLE;
                     end
                  end
               endcase
            end
         end
      end
   end

   // Pattern pixel and bus byte for the position about to be launched.
   always_comb begin
      pix_x   = {1'b0, nxt_p[15:1]};
      pix_y   = nxt_line;
      bar     = pix_x / BAR_W16;
      bar_sel = (bar > 16'd7) ? 3'd7 : bar[2:0];
      pix     = 16'h0000;
      case (nxt_pat)
         2'b00: begin
            case (bar_sel)
               3'd0:    pix = 16'hFFFF;
               3'd1:    pix = 16'hFFE0;
               3'd2:    pix = 16'h07FF;
               3'd3:    pix = 16'h07E0;
               3'd4:    pix = 16'hF81F;
               3'd5:    pix = 16'hF800;
               3'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'b01:   pix = pix_x + (pix_y << 8);
         2'b10:   pix = nxt_solid;
         default: pix = (pix_x[3] ^ pix_y[3]) ? 16'hFFFF : 16'h0000;
      endcase
      href_nxt = (nxt_state == ACTIVE) && (nxt_p < HREF_END);
      byte_nxt = href_nxt ? (nxt_p[0] ? pix[7:0] : pix[15:8]) : 8'h00;
   end

   // Divider runs free; state and bus outputs register on the period boundary.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         div_cnt        <= '0;
         state          <= IDLE;
         p              <= 16'd0;
         line           <= 16'd0;
         pat            <= 2'b00;
         solid          <= 16'h0000;
         vsync_out      <= 1'b0;
         href_out       <= 1'b0;
         data_out       <= 8'h00;
         frame_done_out <= 1'b0;
      end else begin
         div_cnt        <= boundary ? '0 : div_cnt + 1'b1;
         frame_done_out <= frame_end;
         if (boundary) begin
            state     <= nxt_state;
            p         <= nxt_p;
            line      <= nxt_line;
            pat       <= nxt_pat;
            solid     <= nxt_solid;
            vsync_out <= (nxt_state == VSYNC);
            href_out  <= href_nxt;
            data_out  <= byte_nxt;
         end
      end
   end

endmodule

// File: tb/tb_cam_bus_emulator.sv
// Bench for cam_bus_emulator with a tiny frame geometry.
// A bus monitor samples the outputs at each pclk rising edge and compares the
// href bytes against frames built from the pattern rules.
module tb_cam_bus_emulator;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int HB   = 2;
   localparam int VS   = 1;
   localparam int VBP  = 1;
   localparam int VFP  = 1;
   localparam int DIV  = 4;
   localparam int LINE_LEN   = 2 * W + HB;
   localparam int FRAME_CLKS = LINE_LEN * (VS + VBP + H + VFP) * DIV;

   logic        clk_in;
   logic        rst_in;
   logic        en_in;
   logic [1:0]  pattern_in;
   logic [15:0] solid_in;
   logic        pclk_out;
   logic        vsync_out;
   logic        href_out;
   logic [7:0]  data_out;
   logic        frame_done_out;
   logic        busy_out;
   logic [2:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   cam_bus_emulator #(
      .WIDTH(W), .HEIGHT(H), .PCLK_DIV(DIV), .HBLANK(HB),
      .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .en_in(en_in),
      .pattern_in(pattern_in),
      .solid_in(solid_in),
      .pclk_out(pclk_out),
      .vsync_out(vsync_out),
      .href_out(href_out),
      .data_out(data_out),
      .frame_done_out(frame_done_out),
      .busy_out(busy_out),
      .dbg_state_out(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] model_pix(input logic [1:0] pat, input logic [15:0] solid,
                                             input int x, input int y);
      logic [15:0] colours [8];
      int bar_w;
      int bar;
      colours = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      bar_w = (W / 8 > 0) ? W / 8 : 1;
      case (pat)
         2'd0: begin
            bar = x / bar_w;
            if (bar > 7) bar = 7;
            return colours[bar];
         end
         2'd1:    return 16'(x + (y << 8));
         2'd2:    return solid;
         default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
   endfunction

   // ---------------- scoreboard / bus monitor ----------------
   logic [7:0] exp_q[$];
   logic       pclk_q, vs_q, hr_q;
   int         vs_cnt, hr_cnt, burst_cnt, pix_cnt, byte_ph, done_cnt;

   always @(negedge clk_in) begin
      if (!rst_in) begin
         exp_q.delete();
         pclk_q = 1'b0; vs_q = 1'b0; hr_q = 1'b0;
         vs_cnt = 0; hr_cnt = 0; burst_cnt = 0; pix_cnt = 0; byte_ph = 0;
      end else begin
         if (frame_done_out) begin
            check("vsync_pclks", 32'(vs_cnt), 32'(VS * LINE_LEN));
            check("href_pclks", 32'(hr_cnt), 32'(2 * W * H));
            check("href_bursts", 32'(burst_cnt), 32'(H));
            check("rx_pixels", 32'(pix_cnt), 32'(W * H));
            check("bytes_left", 32'(exp_q.size()), 32'd0);
            done_cnt++;
            vs_cnt = 0; hr_cnt = 0; burst_cnt = 0; pix_cnt = 0; byte_ph = 0;
         end
         if (pclk_out && !pclk_q) begin
            if (vsync_out && !vs_q) begin
               // Frame start: the pattern selection presented now is the latched one.
               for (int y = 0; y < H; y++)
                  for (int x = 0; x < W; x++) begin
                     logic [15:0] px;
                     px = model_pix(pattern_in, solid_in, x, y);
                     exp_q.push_back(px[15:8]);
                     exp_q.push_back(px[7:0]);
                  end
            end
            if (vsync_out) vs_cnt++;
            if (href_out) begin
               if (!hr_q) burst_cnt++;
               hr_cnt++;
               if (exp_q.size() == 0) check("href_extra", 32'd1, 32'd0);
               else check("byte", 32'(data_out), 32'(exp_q.pop_front()));
               byte_ph = 1 - byte_ph;
               if (byte_ph == 0) pix_cnt++;
            end else begin
               check("blank_data", 32'(data_out), 32'd0);
            end
            vs_q = vsync_out;
            hr_q = href_out;
         end
         pclk_q = pclk_out;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(output int t);
      t = -1;
      for (int n = 0; n < 2 * FRAME_CLKS + 20; n++) begin
         @(negedge clk_in);
         if (frame_done_out) begin
            t = cyc;
            return;
         end
      end
      check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_href();
      for (int n = 0; n < 2 * FRAME_CLKS + 20; n++) begin
         @(negedge clk_in);
         if (href_out) return;
      end
      check("href_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pclk"}, 32'(pclk_out), 32'd0);
      check({tag, "_vsync"}, 32'(vsync_out), 32'd0);
      check({tag, "_href"}, 32'(href_out), 32'd0);
      check({tag, "_data"}, 32'(data_out), 32'd0);
      check({tag, "_done"}, 32'(frame_done_out), 32'd0);
      check({tag, "_busy"}, 32'(busy_out), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t0, t1, vs_seen, dn_seen;
      rst_in     = 1'b0;
      en_in      = 1'b1;
      pattern_in = 2'b10;
      solid_in   = 16'hABCD;
      done_cnt   = 0;

      // Reset held with enable asserted: everything quiet.
      repeat (5) @(negedge clk_in);
      check_all_zero("rst");

      // Release: pclk 0,0,1,1 and vsync rising at the first period boundary.
      rst_in = 1'b1;
      for (int k = 1; k <= 2 * DIV; k++) begin
         @(posedge clk_in);
         #1;
         check("pclk_phase", 32'(pclk_out), 32'((k % DIV) >= DIV / 2));
         if (k == DIV - 1) check("vsync_early", 32'(vsync_out), 32'd0);
         if (k == DIV)     check("vsync_rise", 32'(vsync_out), 32'd1);
      end

      // Solid-colour frames back to back; period between frame_done pulses.
      wait_done(t0);
      wait_done(t1);
      check("frame_period", 32'(t1 - t0), 32'(FRAME_CLKS));

      // Ramp selected mid-frame: takes effect only from the next frame.
      wait_href();
      pattern_in = 2'b01;
      wait_done(t0);
      wait_done(t0);
      wait_href();
      pattern_in = 2'b00;
      wait_done(t0);
      wait_done(t0);

      // Random pattern/colour changes, always made mid-frame.
      for (int i = 0; i < 5; i++) begin
         wait_href();
         pattern_in = 2'($urandom_range(0, 3));
         solid_in   = 16'($urandom);
         wait_done(t0);
         wait_done(t1);
         check("frame_period_r", 32'(t1 - t0), 32'(FRAME_CLKS));
      end

      // Drop enable during ACTIVE: frame completes, then idle.
      wait_href();
      en_in = 1'b0;
      wait_done(t0);
      check("busy_after_stop", 32'(busy_out), 32'd0);
      vs_seen = 0;
      dn_seen = 0;
      repeat (300) begin
         @(negedge clk_in);
         if (vsync_out) vs_seen++;
         if (frame_done_out) dn_seen++;
      end
      check("idle_vsync", 32'(vs_seen), 32'd0);
      check("idle_done", 32'(dn_seen), 32'd0);
      check("idle_busy", 32'(busy_out), 32'd0);

      // Restart from idle with a random pattern.
      pattern_in = 2'($urandom_range(0, 3));
      solid_in   = 16'($urandom);
      en_in      = 1'b1;
      wait_done(t0);
      wait_done(t0);

      // Asynchronous reset in the middle of an active line.
      wait_href();
      #2 rst_in = 1'b0;
      #1 check_all_zero("async_rst");
      repeat (3) @(negedge clk_in);
      pattern_in = 2'b10;
      solid_in   = 16'($urandom);
      rst_in     = 1'b1;
      wait_done(t0);
      wait_done(t1);
      check("frame_period_post_rst", 32'(t1 - t0), 32'(FRAME_CLKS));
      check("frames_seen", 32'(done_cnt > 10), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
